// File: rtl/flash_read_responder.sv
// Responder for the boot-path flash request/done handshake: issues a Read Array
// command to an Intel-style parallel NOR flash, then an OE-controlled word read.
module flash_read_responder #(
  parameter int CMD_CYCLES  = 2,
  parameter int READ_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        need_to_work,
  input  logic [22:1] addr_in,
  output logic        work_done,
  output logic [15:0] data_out,
  output logic [15:0] done_addr_out,
  output logic [22:1] flash_addr,
  inout  wire  [15:0] flash_data,
  output logic        flash_ce_n,
  output logic        flash_oe_n,
  output logic        flash_we_n,
  output logic        flash_byte_n,
  output logic        flash_vpen,
  output logic        flash_rp_n
);

  localparam int MAXC  = (CMD_CYCLES > READ_CYCLES) ? CMD_CYCLES : READ_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [15:0] READ_ARRAY_CMD = 16'h00FF;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_REC, S_READ, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  logic               drv_q, drv_d;
  logic               done_q, done_d;
  logic [15:0]        data_q, data_d;
  logic [15:0]        daddr_q, daddr_d;
  logic [22:1]        faddr_q, faddr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drv_q   <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      daddr_q <= '0;
      faddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      drv_q   <= drv_d;
      done_q  <= done_d;
      data_q  <= data_d;
      daddr_q <= daddr_d;
      faddr_q <= faddr_d;
    end
  end

  // Strobe registers are loaded one state ahead so each state's pin levels
  // appear in the same cycle the state itself is entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    drv_d   = drv_q;
    done_d  = done_q;
    data_d  = data_q;
    daddr_d = daddr_q;
    faddr_d = faddr_q;
    case (state_q)
      S_IDLE: begin
        if (need_to_work) begin
          faddr_d = addr_in;
          daddr_d = addr_in[16:1];
          cnt_d   = CNT_W'(CMD_CYCLES - 1);
          ce_n_d  = 1'b0;
          we_n_d  = 1'b0;
          drv_d   = 1'b1;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (cnt_q == '0) begin
          we_n_d  = 1'b1;
          state_d = S_REC;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_REC: begin
        // Bus is released on the same edge OE falls, so they never overlap.
        drv_d   = 1'b0;
        oe_n_d  = 1'b0;
        cnt_d   = CNT_W'(READ_CYCLES - 1);
        state_d = S_READ;
      end
      S_READ: begin
        if (cnt_q == '0) begin
          data_d  = flash_data;
          done_d  = 1'b1;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (!need_to_work) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign flash_data    = drv_q ? READ_ARRAY_CMD : 16'hzzzz;
  assign work_done     = done_q;
  assign data_out      = data_q;
  assign done_addr_out = daddr_q;
  assign flash_addr    = faddr_q;
  assign flash_ce_n    = ce_n_q;
  assign flash_oe_n    = oe_n_q;
  assign flash_we_n    = we_n_q;
  assign flash_byte_n  = 1'b1;
  assign flash_vpen    = 1'b1;
  assign flash_rp_n    = 1'b1;

endmodule

// File: tb/tb_flash_read_responder.sv
// Randomized self-checking bench: two responder instances (default and 1/1 timing)
// against a behavioural flash array and handshake/latency expectations.
module tb_flash_read_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        need1 = 1'b0, need2 = 1'b0;
  logic [22:1] addr1 = '0, addr2 = '0;
  logic        wd1, wd2, ce1, ce2, oe1, oe2, we1, we2;
  logic        byte1, byte2, vpen1, vpen2, rp1, rp2;
  logic [15:0] d1, d2, da1, da2;
  logic [22:1] fa1, fa2;
  wire  [15:0] fd1, fd2;
  logic [15:0] key = 16'hA5C2;

  flash_read_responder u_dut1 (
    .clk(clk), .rst(rst), .need_to_work(need1), .addr_in(addr1),
    .work_done(wd1), .data_out(d1), .done_addr_out(da1), .flash_addr(fa1),
    .flash_data(fd1), .flash_ce_n(ce1), .flash_oe_n(oe1), .flash_we_n(we1),
    .flash_byte_n(byte1), .flash_vpen(vpen1), .flash_rp_n(rp1));

  flash_read_responder #(.CMD_CYCLES(1), .READ_CYCLES(1)) u_dut2 (
    .clk(clk), .rst(rst), .need_to_work(need2), .addr_in(addr2),
    .work_done(wd2), .data_out(d2), .done_addr_out(da2), .flash_addr(fa2),
    .flash_data(fd2), .flash_ce_n(ce2), .flash_oe_n(oe2), .flash_we_n(we2),
    .flash_byte_n(byte2), .flash_vpen(vpen2), .flash_rp_n(rp2));

  // Behavioural flash contents: a keyed function of the word address.
  function automatic logic [15:0] word_of(input logic [22:1] a, input logic [15:0] k);
    return (a[16:1] ^ k) + {10'd0, a[22:17]};
  endfunction

  assign fd1 = (!ce1 && !oe1) ? word_of(fa1, key) : 16'hzzzz;
  assign fd2 = (!ce2 && !oe2) ? word_of(fa2, key) : 16'hzzzz;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  bit sel = 1'b0;
  wire        v_wd = sel ? wd2 : wd1;
  wire        v_ce = sel ? ce2 : ce1;
  wire        v_oe = sel ? oe2 : oe1;
  wire        v_we = sel ? we2 : we1;
  wire [15:0] v_d  = sel ? d2  : d1;
  wire [15:0] v_da = sel ? da2 : da1;
  wire [22:1] v_fa = sel ? fa2 : fa1;
  wire [15:0] v_fd = sel ? fd2 : fd1;

  task automatic set_need(input logic v);
    if (sel) need2 = v; else need1 = v;
  endtask

  task automatic set_addr(input logic [22:1] a);
    if (sel) addr2 = a; else addr1 = a;
  endtask

  // One complete request: latency, command/read strobe widths, returned data,
  // then the done hold/release handshake.
  task automatic run_read(input bit s, input logic [22:1] a, input int hold, input bit drop_mid);
    int cmd_c, rd_c, edges, we_cnt, oe_cnt;
    bit seen;
    cmd_c = s ? 1 : 2;
    rd_c  = s ? 1 : 4;
    @(negedge clk);
    sel = s;
    set_addr(a);
    set_need(1'b1);
    edges = 0; we_cnt = 0; oe_cnt = 0; seen = 0;
    while (!seen && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) set_addr(22'($urandom));
      if (drop_mid && edges == cmd_c + 2) set_need(1'b0);
      if (!v_we) begin
        we_cnt++;
        check_eq("cmd_bus", v_fd, 16'h00FF);
      end
      if (!v_oe) oe_cnt++;
      if (!v_oe && !v_we) check_eq("oe_we_overlap", 1, 0);
      if (edges == cmd_c + 1) begin
        check_eq("rec_we", v_we, 1'b1);
        check_eq("rec_bus", v_fd, 16'h00FF);
      end
      if (v_wd) seen = 1;
    end
    check_eq("latency", edges, cmd_c + rd_c + 2);
    check_eq("we_width", we_cnt, cmd_c);
    check_eq("oe_width", oe_cnt, rd_c);
    check_eq("data", v_d, word_of(a, key));
    check_eq("done_addr", v_da, {16'd0, a[16:1]});
    check_eq("flash_addr", v_fa, {10'd0, a});
    check_eq("ce_after", v_ce, 1'b1);
    if (drop_mid) begin
      @(posedge clk); #1;
      check_eq("done_pulse", v_wd, 1'b0);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check_eq("done_hold", v_wd, 1'b1);
      end
      set_need(1'b0);
      @(posedge clk); #1;
      check_eq("done_release", v_wd, 1'b0);
    end
    @(posedge clk); #1;
    check_eq("data_held", v_d, word_of(a, key));
    check_eq("idle_we", v_we, 1'b1);
  endtask

  initial begin
    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("rst_strobes", {ce1, oe1, we1}, 3'b111);
      check_eq("rst_bus_z", (fd1 === 16'hzzzz), 1'b1);
      check_eq("rst_done", wd1, 1'b0);
      check_eq("rst_data", d1, 16'h0000);
    end
    check_eq("tied_pins", {byte1, vpen1, rp1, byte2, vpen2, rp2}, 6'b111111);

    // Directed single read, then handshake hold and a second request
    run_read(1'b0, 22'h000001, 5, 1'b0);
    check_eq("t2_data", d1, 16'hA5C3);
    check_eq("t2_daddr", da1, 16'h0001);
    run_read(1'b0, 22'h000002, 0, 1'b0);
    run_read(1'b0, 22'h000123, 0, 1'b1);

    // Async reset mid-READ
    @(negedge clk);
    sel = 1'b0;
    addr1 = 22'h0ABCDE;
    need1 = 1'b1;
    repeat (5) @(posedge clk);
    #1 check_eq("mid_read_oe", oe1, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_strobes", {ce1, oe1, we1}, 3'b111);
    check_eq("arst_bus_z", (fd1 === 16'hzzzz), 1'b1);
    check_eq("arst_data", d1, 16'h0000);
    need1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check_eq("arst_no_done", wd1, 1'b0);
    end

    // Full-width address on the 1/1 instance
    run_read(1'b1, 22'h3F1234, 1, 1'b0);
    check_eq("t6_daddr", da2, 16'h1234);
    check_eq("t6_faddr", fa2, 22'h3F1234);

    // Randomized traffic on both instances
    key = 16'($urandom);
    for (int n = 0; n < 24; n++) begin
      run_read(1'($urandom), 22'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/flash_read_responder.md
Name: flash_read_responder

Overview:
- Responder side of the flash request/done handshake used by the boot path.
- Accepts a word-address read request, runs the Intel-style parallel NOR read sequence on the board flash pins, and returns the data word.
- Sequence per request: write the Read Array command 0x00FF, then an OE-controlled read.
- Returns the data word, the low 16 bits of the address served, and a done level held until the requester withdraws its request.

Parameters:
- CMD_CYCLES, 2, clock cycles WE_n is held low during the command write (minimum 1).
- READ_CYCLES, 4, clock cycles OE_n is held low before data is sampled (minimum 1).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low.
- need_to_work  input  1  request level from the requester.
- addr_in  input  [22:1]  word address. Sampled only when a request is accepted.
- work_done  output  1  read complete; data_out and done_addr_out are valid.
- data_out  output  16  word read from flash.
- done_addr_out  output  16  addr_in[16:1] latched at acceptance.
- flash_addr  output  [22:1]  flash address pins.
- flash_data  inout  16  flash data bus.
- flash_ce_n, flash_oe_n, flash_we_n  output  1 each  flash strobes.
- flash_byte_n, flash_vpen, flash_rp_n  output  1 each  tied to 1 (x16 mode, not in reset, program voltage enabled).

Behaviour:
- All outputs are registered. flash_data is driven from a registered output-enable; when disabled the bus is high-Z.
- Reset (rst=0, asynchronous, including mid-operation):
  - state=IDLE; work_done=0; data_out=0; done_addr_out=0; flash_addr=0.
  - ce_n=oe_n=we_n=1; bus high-Z; byte_n=vpen=rp_n=1.
  - Any read in flight is abandoned, with no partial work_done.
- IDLE:
  - Strobes are inactive and the bus is high-Z.
  - On an edge with need_to_work=1: latch addr_in into flash_addr, latch addr_in[16:1] into done_addr_out, load counter=CMD_CYCLES-1, go to CMD.
- CMD:
  - ce_n=0, we_n=0, oe_n=1, bus drives 0x00FF.
  - Counter decrements each cycle; at 0 go to REC.
- REC: one cycle with we_n=1, ce_n=0, bus still driving 0x00FF (data hold). Then release the bus, load counter=READ_CYCLES-1, go to READ.
- READ:
  - ce_n=0, oe_n=0, bus high-Z.
  - At counter 0, on that same edge: data_out<=flash_data, work_done<=1, ce_n<=1, oe_n<=1, go to DONE.
- DONE:
  - Strobes are inactive; work_done stays 1 while need_to_work=1.
  - On an edge with need_to_work=0: work_done<=0, go to IDLE.
  - A new request is accepted only from IDLE, so there is at least one idle cycle between consecutive reads.
- Latency:
  - work_done rises on the (CMD_CYCLES+READ_CYCLES+2)th rising edge, counting the accepting edge as 1. Defaults give 8.
  - Back-to-back requests are spaced at least CMD_CYCLES+READ_CYCLES+3 edges.
- need_to_work falling mid-read (CMD/REC/READ): ignored. The read completes, and work_done is high for exactly one cycle before returning to IDLE.
- addr_in changing after acceptance: no effect on the current read.
- data_out and done_addr_out hold their values until the next completed read.
- Width rules:
  - done_addr_out is a truncation of the address; no carry from bits above 16.
  - flash_addr is carried through unmodified, including bit 22.
- The bus is never driven while oe_n=0. oe_n and we_n are never low in the same cycle.

Test Plan:
1. Reset then idle: rst=0 for 3 cycles, need=0 → ce_n/oe_n/we_n=1, bus Z, work_done=0, data_out=0 for 10 cycles after release.
2. Single read with defaults: addr_in=22'h000001, flash model returns 16'hA5C3 → bus=0x00FF with we_n=0 for 2 cycles, oe_n=0 for 4 cycles, work_done=1 on the 8th edge, data_out=16'hA5C3, done_addr_out=16'h0001.
3. Handshake hold/release: keep need=1 for 5 cycles after done → work_done stays 1. Drop need → work_done=0 next edge; need=1 again with addr 22'h000002 → new command write starts the edge after IDLE is reached.
4. Abort-free completion: need drops during READ → read completes, work_done high exactly 1 cycle, data_out updated.
5. Async reset mid-READ: assert rst between edges → strobes go to 1 and the bus goes Z without waiting for a clock edge; work_done never asserts for that read.
6. Address width: addr_in=22'h3F1234, CMD_CYCLES=1, READ_CYCLES=1 → flash_addr=22'h3F1234, done_addr_out=16'h1234, work_done on the 4th edge.
